soma_sched: RTL and testbench

Timestep sequencer for the soma datapath. On each timestep start it sweeps the neuron index range, driving the soma's valid, clear and address controls one neuron per cycle. It captures fire results into a small spike FIFO, drained by the axon/router side with a valid/ready handshake. It also gates the host configuration access port, so that host membrane-memory writes never collide with the soma write-back cycle.

---
 rtl/soma_sched.sv | 199 +++++++++++++++++++
 tb/tb_soma_sched.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soma_sched.sv
// Timestep sequencer for the soma datapath: sweeps neuron indices, captures
// fire results into a spike FIFO and arbitrates host access to the Vm port.
module soma_sched #(
  parameter int unsigned NNW     = 12,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic           clk_soma,
  input  logic           rst_n,
  input  logic           enable,
  input  logic           start,
  input  logic           clear_mode,
  input  logic [NNW-1:0] nrn_num,
  input  logic           soma_fire,
  output logic           soma_vld,
  output logic           soma_clear,
  output logic [NNW-1:0] soma_addr,
  output logic           busy,
  output logic           done,
  output logic           overrun,
  output logic           spk_valid,
  output logic [NNW-1:0] spk_addr,
  input  logic           spk_ready,
  input  logic           host_req,
  output logic           host_gnt
);

  localparam int unsigned DEPTH = 32'(1) << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // FSM and control registers
  state_t           state_q, state_d;
  logic [NNW-1:0]   idx_q, idx_d;
  logic [NNW-1:0]   num_q, num_d;
  logic             clear_q, clear_d;
  logic             pend_q, pend_d;
  logic             gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic             sclr_q, sclr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  // Capture stage and spike FIFO
  logic             cap_vld_q;
  logic             cap_nc_q;
  logic [NNW-1:0]   cap_addr_q;
  logic [NNW-1:0]   mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, rd_q;
  logic [FIFO_AW-1:0] wr_nxt, rd_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             fvalid_q;
  logic [NNW-1:0]   head_q, head_nxt;

  logic             push;
  logic             pop;
  logic             start_en;
  logic             accept;
  logic             inflight_nxt;
  logic [CW-1:0]    occ_nxt;

  assign push     = cap_vld_q & cap_nc_q & soma_fire;
  assign pop      = fvalid_q & spk_ready;
  assign cnt_nxt  = cnt_q + CW'(push) - CW'(pop);
  assign rd_nxt   = rd_q + FIFO_AW'(pop);
  assign wr_nxt   = wr_q + FIFO_AW'(push);
  assign start_en = start & enable;
  assign accept   = (state_q == S_IDLE) & ~gnt_q & (start_en | pend_q);

  // An issue this cycle becomes the in-flight entry of the next cycle's rule
  assign inflight_nxt = vld_q & ~clear_q;
  assign occ_nxt      = cnt_nxt + CW'(inflight_nxt);

  // New head: a push landing at the post-pop read pointer bypasses the array
  always_comb begin
    head_nxt = head_q;
    if (cnt_nxt != '0) begin
      if (push && (wr_q == rd_nxt)) head_nxt = cap_addr_q;
      else                          head_nxt = mem_q[rd_nxt];
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    num_d   = num_q;
    clear_d = clear_q;
    pend_d  = pend_q;
    vld_d   = 1'b0;
    sclr_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ovr_d   = start_en & (state_q != S_IDLE);
    gnt_d   = host_req & (gnt_q | ((state_q == S_IDLE) & ~accept));

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          num_d   = nrn_num;
          clear_d = clear_mode;
          idx_d   = '0;
          pend_d  = 1'b0;
          state_d = (nrn_num == '0) ? S_DONE : S_SWEEP;
        end else if (start_en && gnt_q) begin
          pend_d = 1'b1;
        end
      end
      S_SWEEP: begin
        if (vld_q) begin
          if (idx_q == num_q - NNW'(1)) state_d = S_DRAIN;
          else                          idx_d   = idx_q + NNW'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_SWEEP) begin
      vld_d  = clear_d | (occ_nxt < CW'(DEPTH));
      sclr_d = clear_d;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      num_q   <= '0;
      clear_q <= 1'b0;
      pend_q  <= 1'b0;
      gnt_q   <= 1'b0;
      vld_q   <= 1'b0;
      sclr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      clear_q <= clear_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      sclr_q  <= sclr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Capture pipeline, FIFO pointers and registered head
  always_ff @(posedge clk_soma or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld_q  <= 1'b0;
      cap_nc_q   <= 1'b0;
      cap_addr_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      fvalid_q   <= 1'b0;
      head_q     <= '0;
    end else begin
      cap_vld_q  <= vld_q;
      cap_nc_q   <= ~clear_q;
      cap_addr_q <= idx_q;
      wr_q       <= wr_nxt;
      rd_q       <= rd_nxt;
      cnt_q      <= cnt_nxt;
      fvalid_q   <= (cnt_nxt != '0);
      head_q     <= head_nxt;
    end
  end

  always_ff @(posedge clk_soma) begin
    if (push) mem_q[wr_q] <= cap_addr_q;
  end

  assign soma_vld   = vld_q;
  assign soma_clear = sclr_q;
  assign soma_addr  = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overrun    = ovr_q;
  assign spk_valid  = fvalid_q;
  assign spk_addr   = head_q;
  assign host_gnt   = gnt_q;

endmodule

// File: tb/tb_soma_sched.sv
// Directed bench for soma_sched: sweep timing, FIFO back-pressure, clear
// sweeps, host arbitration, overrun and mid-sweep reset.
module tb_soma_sched;

  localparam int unsigned NNW = 12;

  logic           clk_soma;
  logic           rst_n;
  logic           enable;
  logic           start;
  logic           clear_mode;
  logic [NNW-1:0] nrn_num;
  logic           soma_fire;
  logic           soma_vld;
  logic           soma_clear;
  logic [NNW-1:0] soma_addr;
  logic           busy;
  logic           done;
  logic           overrun;
  logic           spk_valid;
  logic [NNW-1:0] spk_addr;
  logic           spk_ready;
  logic           host_req;
  logic           host_gnt;

  soma_sched #(.NNW(NNW), .FIFO_AW(3)) dut (
    .clk_soma   (clk_soma),
    .rst_n      (rst_n),
    .enable     (enable),
    .start      (start),
    .clear_mode (clear_mode),
    .nrn_num    (nrn_num),
    .soma_fire  (soma_fire),
    .soma_vld   (soma_vld),
    .soma_clear (soma_clear),
    .soma_addr  (soma_addr),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .spk_valid  (spk_valid),
    .spk_addr   (spk_addr),
    .spk_ready  (spk_ready),
    .host_req   (host_req),
    .host_gnt   (host_gnt)
  );

  initial begin
    clk_soma = 1'b0;
    forever #5 clk_soma = ~clk_soma;
  end

  int checks = 0;
  int errors = 0;
  int sbq[$];
  int cyc = 0;
  int exp_issue, vld_cnt, clr_cnt, pop_cnt, spk_seen;
  int first_vld_cyc, last_vld_cyc, done_cyc, first_spk_cyc, start_cyc;
  bit exp_clear;
  bit done_seen;
  bit fire_all;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    exp_issue = 0; vld_cnt = 0; clr_cnt = 0; pop_cnt = 0; spk_seen = 0;
    first_vld_cyc = -1; last_vld_cyc = -1; done_cyc = -1; first_spk_cyc = -1;
    done_seen = 1'b0;
  endtask

  // Per-cycle observation of issues, done and spike handshakes
  task automatic monitor();
    int e;
    if (soma_vld) begin
      chk("issue_addr", 32'(soma_addr), 32'(exp_issue));
      chk("issue_clear", 32'(soma_clear), 32'(exp_clear));
      if (vld_cnt == 0) first_vld_cyc = cyc;
      last_vld_cyc = cyc;
      vld_cnt++;
      exp_issue++;
    end
    if (soma_clear) clr_cnt++;
    if (done) begin
      done_seen = 1'b1;
      done_cyc = cyc;
    end
    if (spk_valid) begin
      if (spk_seen == 0) first_spk_cyc = cyc;
      spk_seen++;
    end
    if (spk_valid && spk_ready) begin
      chk("spk_q_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("spk_addr", 32'(spk_addr), 32'(e));
      end
      pop_cnt++;
    end
  endtask

  task automatic tick();
    @(negedge clk_soma);
    monitor();
    @(posedge clk_soma);
    #1;
    cyc++;
    soma_fire = fire_all;
  endtask

  task automatic pulse_start(input int nn, input bit clr);
    clear_stats();
    exp_clear  = clr;
    nrn_num    = NNW'(nn);
    clear_mode = clr;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    start_cyc  = cyc;
  endtask

  task automatic push_expected(input int n);
    for (int i = 0; i < n; i++) sbq.push_back(i);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
  endtask

  task automatic drain_wait(input int budget);
    int n = 0;
    while ((spk_valid || sbq.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    chk("fifo_empty", 32'(spk_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; start = 1'b0; clear_mode = 1'b0;
    nrn_num = '0; soma_fire = 1'b0; spk_ready = 1'b0; host_req = 1'b0;
    fire_all = 1'b1;
    exp_clear = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk_soma);
    #1;
    chk("rst_vld", 32'(soma_vld), 0);
    chk("rst_clear", 32'(soma_clear), 0);
    chk("rst_addr", 32'(soma_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_spk_valid", 32'(spk_valid), 0);
    chk("rst_spk_addr", 32'(spk_addr), 0);
    chk("rst_gnt", 32'(host_gnt), 0);
    @(negedge clk_soma);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_fire_ignored", 32'(spk_valid), 0);

    // Short unstalled sweep
    spk_ready = 1'b1;
    push_expected(4);
    pulse_start(4, 1'b0);
    wait_done(50);
    chk("t1_vld_cnt", 32'(vld_cnt), 32'd4);
    chk("t1_first_vld", 32'(first_vld_cyc), 32'(start_cyc));
    chk("t1_last_vld", 32'(last_vld_cyc), 32'(start_cyc + 3));
    chk("t1_done_cyc", 32'(done_cyc), 32'(start_cyc + 5));
    chk("t1_first_spk", 32'(first_spk_cyc), 32'(start_cyc + 2));
    chk("t1_busy_low", 32'(busy), 0);
    chk("t1_done_low", 32'(done), 0);
    drain_wait(50);
    chk("t1_pops", 32'(pop_cnt), 32'd4);

    // Back-pressure: FIFO fills, sweep stalls at index 8
    spk_ready = 1'b0;
    push_expected(20);
    pulse_start(20, 1'b0);
    repeat (30) tick();
    chk("t2_vld_cnt_stall", 32'(vld_cnt), 32'd8);
    chk("t2_stall_vld", 32'(soma_vld), 0);
    chk("t2_stall_addr", 32'(soma_addr), 32'd8);
    chk("t2_busy", 32'(busy), 1);
    chk("t2_spk_valid", 32'(spk_valid), 1);
    chk("t2_head", 32'(spk_addr), 0);
    spk_ready = 1'b1;
    wait_done(200);
    drain_wait(50);
    chk("t2_vld_cnt", 32'(vld_cnt), 32'd20);
    chk("t2_pops", 32'(pop_cnt), 32'd20);

    // Clear sweep: no stalls, no spikes
    pulse_start(16, 1'b1);
    wait_done(100);
    chk("t3_vld_cnt", 32'(vld_cnt), 32'd16);
    chk("t3_clr_cnt", 32'(clr_cnt), 32'd16);
    chk("t3_done_cyc", 32'(done_cyc), 32'(start_cyc + 17));
    tick();
    tick();
    chk("t3_no_spikes", 32'(spk_seen), 0);
    chk("t3_soma_clear_low", 32'(soma_clear), 0);

    // Empty sweep goes straight to DONE
    pulse_start(0, 1'b0);
    wait_done(20);
    chk("t4_vld_cnt", 32'(vld_cnt), 0);
    chk("t4_done_cyc", 32'(done_cyc), 32'(start_cyc));

    // Host grant defers a start until the grant is released
    host_req = 1'b1;
    tick();
    tick();
    chk("t5_gnt", 32'(host_gnt), 1);
    push_expected(3);
    pulse_start(3, 1'b0);
    chk("t5_no_overrun", 32'(overrun), 0);
    repeat (3) tick();
    chk("t5_held_busy", 32'(busy), 0);
    chk("t5_held_vld", 32'(vld_cnt), 0);
    chk("t5_held_gnt", 32'(host_gnt), 1);
    host_req = 1'b0;
    tick();
    chk("t5_gnt_drop", 32'(host_gnt), 0);
    chk("t5_busy_pre", 32'(busy), 0);
    tick();
    chk("t5_vld", 32'(soma_vld), 1);
    chk("t5_addr", 32'(soma_addr), 0);
    chk("t5_busy", 32'(busy), 1);
    wait_done(50);
    drain_wait(50);
    chk("t5_vld_cnt", 32'(vld_cnt), 32'd3);

    // Start while busy is an overrun and is otherwise ignored
    push_expected(10);
    pulse_start(10, 1'b0);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_overrun", 32'(overrun), 1);
    tick();
    chk("t6_overrun_pulse", 32'(overrun), 0);
    wait_done(60);
    drain_wait(50);
    chk("t6_vld_cnt", 32'(vld_cnt), 32'd10);
    chk("t6_pops", 32'(pop_cnt), 32'd10);

    // Disabled start is dropped silently
    enable = 1'b0;
    nrn_num = NNW'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t7_dis_overrun", 32'(overrun), 0);
    tick();
    chk("t7_dis_busy", 32'(busy), 0);
    enable = 1'b1;

    // Reset mid-sweep, then a normal sweep
    push_expected(12);
    pulse_start(12, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #2;
    chk("t8_rst_vld", 32'(soma_vld), 0);
    chk("t8_rst_busy", 32'(busy), 0);
    chk("t8_rst_addr", 32'(soma_addr), 0);
    chk("t8_rst_spk_valid", 32'(spk_valid), 0);
    chk("t8_rst_spk_addr", 32'(spk_addr), 0);
    chk("t8_rst_done", 32'(done), 0);
    sbq.delete();
    @(negedge clk_soma);
    rst_n = 1'b1;
    tick();
    tick();
    push_expected(4);
    pulse_start(4, 1'b0);
    wait_done(50);
    drain_wait(50);
    chk("t8_vld_cnt", 32'(vld_cnt), 32'd4);
    chk("t8_done_cyc", 32'(done_cyc), 32'(start_cyc + 5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
